// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: shares one single-port data memory between the core
// memory controller (core_*) and an external DMA/debug master (dma_*).
//   - Zero-latency combinational grant; mem_* driven from the granted side.
//   - Lock handshake keeps ownership across read-modify-write pairs.
//   - DMA starvation counter lets DMA win a conflict after STARVE_LIMIT
//     consecutive denied cycles.
//   - Read data returns one cycle after the grant, steered by a read tag.
// Ports:
//   clock, reset            system clock, async active-high reset
//   core_* / dma_*          requester ports (req/write/lock/addr/wdata/be in,
//                           gnt/rvalid/rdata out)
//   mem_*                   memory backend (en/we/addr/wdata/be out, rdata in)
// Optional build macro MEMORY_PORT_ARBITER_PERF_COUNTERS_EN adds
//   perf_core_grants, perf_dma_grants, perf_conflict_cycles (32-bit, wrapping).
module memory_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 30,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    core_req,
  input  logic                    core_write,
  input  logic                    core_lock,
  input  logic [ADDR_WIDTH-1:0]   core_addr,
  input  logic [DATA_WIDTH-1:0]   core_wdata,
  input  logic [DATA_WIDTH/8-1:0] core_be,
  output logic                    core_gnt,
  output logic                    core_rvalid,
  output logic [DATA_WIDTH-1:0]   core_rdata,
  input  logic                    dma_req,
  input  logic                    dma_write,
  input  logic                    dma_lock,
  input  logic [ADDR_WIDTH-1:0]   dma_addr,
  input  logic [DATA_WIDTH-1:0]   dma_wdata,
  input  logic [DATA_WIDTH/8-1:0] dma_be,
  output logic                    dma_gnt,
  output logic                    dma_rvalid,
  output logic [DATA_WIDTH-1:0]   dma_rdata,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
`ifdef MEMORY_PORT_ARBITER_PERF_COUNTERS_EN
  ,
  output logic [31:0]             perf_core_grants,
  output logic [31:0]             perf_dma_grants,
  output logic [31:0]             perf_conflict_cycles
`endif
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_CORE_LOCKED = 2'd1,
    ST_DMA_LOCKED  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        starve_q, starve_d;
  logic                    rd_core_q, rd_dma_q;
  logic [DATA_WIDTH-1:0]   core_rdata_q, dma_rdata_q;
  logic                    dma_starved;

  assign dma_starved = (starve_q >= CNT_W'(STARVE_LIMIT));

  // Grant and next-state; grants are forced low while reset is asserted.
  always_comb begin
    core_gnt = 1'b0;
    dma_gnt  = 1'b0;
    state_d  = state_q;
    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          if (core_req && dma_req) begin
            if (dma_starved) dma_gnt  = 1'b1;
            else             core_gnt = 1'b1;
          end else begin
            core_gnt = core_req;
            dma_gnt  = dma_req;
          end
        end
        ST_CORE_LOCKED: core_gnt = core_req;
        ST_DMA_LOCKED:  dma_gnt  = dma_req;
        default:        state_d  = ST_IDLE;
      endcase
      // Owner's lock bit on a granted access decides whether ownership persists.
      if (core_gnt)     state_d = core_lock ? ST_CORE_LOCKED : ST_IDLE;
      else if (dma_gnt) state_d = dma_lock ? ST_DMA_LOCKED : ST_IDLE;
    end
  end

  // Starvation counter: counts denied DMA cycles, saturating.
  always_comb begin
    starve_d = starve_q;
    if (dma_gnt || !dma_req)        starve_d = '0;
    else if (starve_q != {CNT_W{1'b1}}) starve_d = starve_q + CNT_W'(1);
  end

  // Memory request mux follows the granted side.
  always_comb begin
    mem_en    = core_gnt | dma_gnt;
    mem_we    = 1'b0;
    mem_addr  = core_addr;
    mem_wdata = core_wdata;
    mem_be    = core_be;
    if (dma_gnt) begin
      mem_we    = dma_write;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_be    = dma_be;
    end else if (core_gnt) begin
      mem_we    = core_write;
    end
  end

  // Returning port sees memory data directly; the other holds its last value.
  assign core_rvalid = rd_core_q;
  assign dma_rvalid  = rd_dma_q;
  assign core_rdata  = rd_core_q ? mem_rdata : core_rdata_q;
  assign dma_rdata   = rd_dma_q  ? mem_rdata : dma_rdata_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      starve_q     <= '0;
      rd_core_q    <= 1'b0;
      rd_dma_q     <= 1'b0;
      core_rdata_q <= '0;
      dma_rdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      rd_core_q <= core_gnt & ~core_write;
      rd_dma_q  <= dma_gnt & ~dma_write;
      if (rd_core_q) core_rdata_q <= mem_rdata;
      if (rd_dma_q)  dma_rdata_q  <= mem_rdata;
    end
  end

`ifdef MEMORY_PORT_ARBITER_PERF_COUNTERS_EN
  logic [31:0] perf_core_q, perf_dma_q, perf_conf_q;
  logic        conflict;

  // Conflict: both requesting, or the non-owner requesting while locked out.
  assign conflict = (core_req && dma_req) ||
                    (state_q == ST_CORE_LOCKED && dma_req) ||
                    (state_q == ST_DMA_LOCKED && core_req);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_core_q <= '0;
      perf_dma_q  <= '0;
      perf_conf_q <= '0;
    end else begin
      if (core_gnt) perf_core_q <= perf_core_q + 32'd1;
      if (dma_gnt)  perf_dma_q  <= perf_dma_q + 32'd1;
      if (conflict) perf_conf_q <= perf_conf_q + 32'd1;
    end
  end

  assign perf_core_grants     = perf_core_q;
  assign perf_dma_grants      = perf_dma_q;
  assign perf_conflict_cycles = perf_conf_q;
`endif

endmodule
